vlsu_meta_seq: RTL and testbench

VLSU_META_SEQ -- requirements
Module: vlsu_meta_seq

---
 rtl/vlsu_meta_seq_if.sv | 55 +++++
 rtl/vlsu_meta_seq.sv | 170 +++++++++++++++++
 tb/tb_vlsu_meta_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vlsu_meta_seq_if.sv
// Request and meta handshake bundle for the vector LSU meta sequencer.
// Field names of the meta payloads follow the transaction control unit's naming.
interface vlsu_meta_seq_if #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned CntWidth    = 8,
  parameter int unsigned SegNibWidth = 20
);
  localparam int unsigned PageBits = 13;
  localparam int unsigned TxnWidth = SegNibWidth + 1 - PageBits;
  localparam int unsigned LtnWidth = PageBits + 1;

  typedef struct packed {
    logic [IdWidth-1:0]  reqId;
    logic                isLoad;
    logic [CntWidth-1:0] rmnGrp;
    logic [CntWidth-1:0] rmnSeg;
  } meta_glb_t;

  typedef struct packed {
    logic [AddrWidth-1:0] segBaseAddr;
    logic [TxnWidth-1:0]  txnCnt;
    logic [TxnWidth-1:0]  txnNum;
    logic [LtnWidth-1:0]  ltN;
  } meta_seglv_t;

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [IdWidth-1:0]     req_id_i;
  logic                   req_is_load_i;
  logic [AddrWidth-1:0]   req_base_i;
  logic [CntWidth-1:0]    req_grp_num_i;
  logic [CntWidth-1:0]    req_seg_num_i;
  logic [AddrWidth-1:0]   req_grp_stride_i;
  logic [AddrWidth-1:0]   req_seg_stride_i;
  logic [SegNibWidth-1:0] req_seg_nib_i;
  logic                   meta_valid_o;
  logic                   meta_ready_i;
  meta_glb_t              meta_glb_o;
  meta_seglv_t            meta_seglv_o;

  modport slave (
    input  req_valid_i, req_id_i, req_is_load_i, req_base_i, req_grp_num_i,
           req_seg_num_i, req_grp_stride_i, req_seg_stride_i, req_seg_nib_i,
           meta_ready_i,
    output req_ready_o, meta_valid_o, meta_glb_o, meta_seglv_o
  );

  modport master (
    output req_valid_i, req_id_i, req_is_load_i, req_base_i, req_grp_num_i,
           req_seg_num_i, req_grp_stride_i, req_seg_stride_i, req_seg_nib_i,
           meta_ready_i,
    input  req_ready_o, meta_valid_o, meta_glb_o, meta_seglv_o
  );
endinterface

// File: rtl/vlsu_meta_seq.sv
// Walks a grouped/segmented strided request and emits one meta beat per
// 8 KiB-nibble page transaction touched by each segment.
module vlsu_meta_seq #(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned CntWidth    = 8,
  parameter int unsigned SegNibWidth = 20
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  vlsu_meta_seq_if.slave bus,
  output logic           busy_o,
  output logic           done_o
);
  localparam int unsigned PageBits = 13;
  localparam int unsigned EndWidth = SegNibWidth + 1;
  localparam int unsigned TxnWidth = EndWidth - PageBits;
  localparam int unsigned LtnWidth = PageBits + 1;

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_e;

  state_e                 state_q, state_d;
  logic [IdWidth-1:0]     req_id_q, req_id_d;
  logic                   is_load_q, is_load_d;
  logic [AddrWidth-1:0]   grp_stride_q, grp_stride_d;
  logic [AddrWidth-1:0]   seg_stride_q, seg_stride_d;
  logic [CntWidth-1:0]    seg_num_q, seg_num_d;
  logic [SegNibWidth-1:0] seg_nib_q, seg_nib_d;
  logic                   zero_len_q, zero_len_d;
  logic [AddrWidth-1:0]   grp_addr_q, grp_addr_d;
  logic [AddrWidth-1:0]   seg_addr_q, seg_addr_d;
  logic [CntWidth-1:0]    rmn_grp_q, rmn_grp_d;
  logic [CntWidth-1:0]    rmn_seg_q, rmn_seg_d;
  logic [TxnWidth-1:0]    txn_cnt_q, txn_cnt_d;
  logic [TxnWidth-1:0]    txn_num_q, txn_num_d;
  logic [LtnWidth-1:0]    ltn_q, ltn_d;
  logic                   req_ready_q, req_ready_d;
  logic                   meta_valid_q, meta_valid_d;
  logic                   busy_q, busy_d;
  logic [EndWidth-1:0]    seg_end_c;
  logic                   done_c;

  always_comb begin
    state_d      = state_q;
    req_id_d     = req_id_q;
    is_load_d    = is_load_q;
    grp_stride_d = grp_stride_q;
    seg_stride_d = seg_stride_q;
    seg_num_d    = seg_num_q;
    seg_nib_d    = seg_nib_q;
    zero_len_d   = zero_len_q;
    grp_addr_d   = grp_addr_q;
    seg_addr_d   = seg_addr_q;
    rmn_grp_d    = rmn_grp_q;
    rmn_seg_d    = rmn_seg_q;
    txn_cnt_d    = txn_cnt_q;
    txn_num_d    = txn_num_q;
    ltn_d        = ltn_q;
    done_c       = 1'b0;
    // Last nibble of the segment relative to the start of its first page
    seg_end_c    = EndWidth'(seg_addr_q[PageBits-1:0]) + EndWidth'(seg_nib_q)
                 - EndWidth'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          req_id_d     = bus.req_id_i;
          is_load_d    = bus.req_is_load_i;
          grp_stride_d = bus.req_grp_stride_i;
          seg_stride_d = bus.req_seg_stride_i;
          seg_num_d    = bus.req_seg_num_i;
          seg_nib_d    = bus.req_seg_nib_i;
          zero_len_d   = (bus.req_seg_nib_i == '0);
          grp_addr_d   = bus.req_base_i;
          seg_addr_d   = bus.req_base_i;
          rmn_grp_d    = bus.req_grp_num_i;
          rmn_seg_d    = bus.req_seg_num_i;
          state_d      = CALC;
        end
      end
      CALC: begin
        // A zero-length request only spends this cycle signalling completion
        if (zero_len_q) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else begin
          txn_num_d = TxnWidth'(seg_end_c >> PageBits);
          ltn_d     = LtnWidth'(seg_end_c[PageBits-1:0]) + LtnWidth'(1);
          txn_cnt_d = '0;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (bus.meta_ready_i) begin
          if (txn_cnt_q != txn_num_q) begin
            txn_cnt_d = txn_cnt_q + TxnWidth'(1);
          end else if (rmn_seg_q != '0) begin
            seg_addr_d = seg_addr_q + seg_stride_q;
            rmn_seg_d  = rmn_seg_q - CntWidth'(1);
            state_d    = CALC;
          end else if (rmn_grp_q != '0) begin
            grp_addr_d = grp_addr_q + grp_stride_q;
            seg_addr_d = grp_addr_q + grp_stride_q;
            rmn_seg_d  = seg_num_q;
            rmn_grp_d  = rmn_grp_q - CntWidth'(1);
            state_d    = CALC;
          end else begin
            done_c  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    meta_valid_d = (state_d == EMIT);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_id_q     <= '0;
      is_load_q    <= 1'b0;
      grp_stride_q <= '0;
      seg_stride_q <= '0;
      seg_num_q    <= '0;
      seg_nib_q    <= '0;
      zero_len_q   <= 1'b0;
      grp_addr_q   <= '0;
      seg_addr_q   <= '0;
      rmn_grp_q    <= '0;
      rmn_seg_q    <= '0;
      txn_cnt_q    <= '0;
      txn_num_q    <= '0;
      ltn_q        <= '0;
      req_ready_q  <= 1'b1;
      meta_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_id_q     <= req_id_d;
      is_load_q    <= is_load_d;
      grp_stride_q <= grp_stride_d;
      seg_stride_q <= seg_stride_d;
      seg_num_q    <= seg_num_d;
      seg_nib_q    <= seg_nib_d;
      zero_len_q   <= zero_len_d;
      grp_addr_q   <= grp_addr_d;
      seg_addr_q   <= seg_addr_d;
      rmn_grp_q    <= rmn_grp_d;
      rmn_seg_q    <= rmn_seg_d;
      txn_cnt_q    <= txn_cnt_d;
      txn_num_q    <= txn_num_d;
      ltn_q        <= ltn_d;
      req_ready_q  <= req_ready_d;
      meta_valid_q <= meta_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.meta_valid_o = meta_valid_q;
  assign bus.meta_glb_o   = {req_id_q, is_load_q, rmn_grp_q, rmn_seg_q};
  assign bus.meta_seglv_o = {seg_addr_q, txn_cnt_q, txn_num_q, ltn_q};
  assign busy_o           = busy_q;
  // Completion is tied to the final handshake; suppressed while reset is applied
  assign done_o           = done_c & rst_ni;
endmodule

// File: tb/tb_vlsu_meta_seq.sv
// Directed, cycle-exact bench for vlsu_meta_seq: page crossing, exact page,
// strided groups, backpressure, zero length and mid-request reset.
module tb_vlsu_meta_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic done;
  int   n_checks = 0;
  int   n_fail   = 0;

  vlsu_meta_seq_if bus ();

  vlsu_meta_seq dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int id, input bit ld, input longint base, input int grp,
                     input int seg, input longint gs, input longint ss, input int nib);
    bus.req_valid_i      = 1'b1;
    bus.req_id_i         = 4'(id);
    bus.req_is_load_i    = ld;
    bus.req_base_i       = 64'(base);
    bus.req_grp_num_i    = 8'(grp);
    bus.req_seg_num_i    = 8'(seg);
    bus.req_grp_stride_i = 64'(gs);
    bus.req_seg_stride_i = 64'(ss);
    bus.req_seg_nib_i    = 20'(nib);
    @(negedge clk);
    chk("req_ready", 128'(bus.req_ready_o), 128'(1));
    cyc();
    bus.req_valid_i = 1'b0;
  endtask

  // One CALC bubble: no meta, no done, still busy
  task automatic gap(input string tag);
    @(negedge clk);
    chk({tag, "_gap_valid"}, 128'(bus.meta_valid_o), 128'(0));
    chk({tag, "_gap_busy"}, 128'(busy), 128'(1));
    chk({tag, "_gap_done"}, 128'(done), 128'(0));
    cyc();
  endtask

  task automatic look(input string tag, input int id, input bit ld, input int g, input int s,
                      input longint addr, input int cnt, input int num, input int ltn,
                      input bit dn);
    logic [127:0] eg;
    logic [127:0] es;
    eg = {107'b0, 4'(id), ld, 8'(g), 8'(s)};
    es = {34'b0, 64'(addr), 8'(cnt), 8'(num), 14'(ltn)};
    @(negedge clk);
    chk({tag, "_valid"}, 128'(bus.meta_valid_o), 128'(1));
    chk({tag, "_glb"}, 128'(bus.meta_glb_o), eg);
    chk({tag, "_seglv"}, 128'(bus.meta_seglv_o), es);
    chk({tag, "_done"}, 128'(done), 128'(dn));
  endtask

  task automatic beat(input string tag, input int id, input bit ld, input int g, input int s,
                      input longint addr, input int cnt, input int num, input int ltn,
                      input bit dn);
    bus.meta_ready_i = 1'b1;
    look(tag, id, ld, g, s, addr, cnt, num, ltn, dn);
    cyc();
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, 128'(bus.req_ready_o), 128'(1));
    chk({tag, "_valid"}, 128'(bus.meta_valid_o), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.req_valid_i      = 1'b0;
    bus.req_id_i         = '0;
    bus.req_is_load_i    = 1'b0;
    bus.req_base_i       = '0;
    bus.req_grp_num_i    = '0;
    bus.req_seg_num_i    = '0;
    bus.req_grp_stride_i = '0;
    bus.req_seg_stride_i = '0;
    bus.req_seg_nib_i    = '0;
    bus.meta_ready_i     = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
    idle_chk("reset");

    // Page cross: 0x1FF0 + 0x20 nibbles spans two pages
    cyc();
    req(3, 1'b1, 64'h1FF0, 0, 0, 0, 0, 'h20);
    gap("pc");
    beat("pc0", 3, 1'b1, 0, 0, 64'h1FF0, 0, 1, 'h10, 1'b0);
    beat("pc1", 3, 1'b1, 0, 0, 64'h1FF0, 1, 1, 'h10, 1'b1);
    idle_chk("pc_end");

    // Exact page
    cyc();
    req(5, 1'b0, 64'h0, 0, 0, 0, 0, 'h2000);
    gap("ep");
    beat("ep0", 5, 1'b0, 0, 0, 64'h0, 0, 0, 'h2000, 1'b1);
    idle_chk("ep_end");

    // Two groups of two segments
    cyc();
    req(7, 1'b1, 64'h100, 1, 1, 64'h1000, 64'h40, 'h10);
    gap("sg_a");
    beat("sg0", 7, 1'b1, 1, 1, 64'h100,  0, 0, 'h110,  1'b0);
    gap("sg_b");
    beat("sg1", 7, 1'b1, 1, 0, 64'h140,  0, 0, 'h150,  1'b0);
    gap("sg_c");
    beat("sg2", 7, 1'b1, 0, 1, 64'h1100, 0, 0, 'h1110, 1'b0);
    gap("sg_d");
    beat("sg3", 7, 1'b1, 0, 0, 64'h1140, 0, 0, 'h1150, 1'b1);
    idle_chk("sg_end");

    // Backpressure mid-segment: 0x1FF0 + 0x4020 nibbles -> 4 transactions
    cyc();
    req(9, 1'b0, 64'h1FF0, 0, 0, 0, 0, 'h4020);
    gap("bp");
    beat("bp0", 9, 1'b0, 0, 0, 64'h1FF0, 0, 3, 'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.meta_ready_i = 1'b0;
      look("bp_hold", 9, 1'b0, 0, 0, 64'h1FF0, 1, 3, 'h10, 1'b0);
      cyc();
    end
    beat("bp1", 9, 1'b0, 0, 0, 64'h1FF0, 1, 3, 'h10, 1'b0);
    beat("bp2", 9, 1'b0, 0, 0, 64'h1FF0, 2, 3, 'h10, 1'b0);
    beat("bp3", 9, 1'b0, 0, 0, 64'h1FF0, 3, 3, 'h10, 1'b1);
    idle_chk("bp_end");

    // Zero length: completion flagged in the cycle after the handshake, no meta
    cyc();
    req(2, 1'b1, 64'h500, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zl_valid", 128'(bus.meta_valid_o), 128'(0));
    chk("zl_done", 128'(done), 128'(1));
    chk("zl_ready", 128'(bus.req_ready_o), 128'(0));
    cyc();
    idle_chk("zl_end");

    // Reset while emitting, then a clean request
    cyc();
    req(4, 1'b0, 64'h1FF0, 0, 0, 0, 0, 'h4020);
    gap("rs");
    beat("rs0", 4, 1'b0, 0, 0, 64'h1FF0, 0, 3, 'h10, 1'b0);
    rst_n            = 1'b0;
    bus.meta_ready_i = 1'b0;
    cyc();
    rst_n            = 1'b1;
    bus.meta_ready_i = 1'b1;
    idle_chk("rs_a");
    cyc();
    idle_chk("rs_b");
    cyc();
    req(6, 1'b1, 64'h0, 0, 0, 0, 0, 'h2000);
    gap("rs_n");
    beat("rs_n0", 6, 1'b1, 0, 0, 64'h0, 0, 0, 'h2000, 1'b1);
    idle_chk("rs_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
